pe_job_scheduler: RTL and testbench
===================================

// Module: pe_job_scheduler
// PURPOSE
//  Sequences back-to-back convolution jobs onto a single Eyeriss processing element.
//  Queues job descriptors {id, filter_size, stride} in a small FIFO.
//  For each job: drives the PE's config inputs, pulses its start, grants ready and
//  counts psum writes until the PE reports done. Then returns a completion record.
//  Sits between the global control/host and one PE instance.
// PARAMETERS
//  FILTER_W  2  width of filter_size (matches PE filter_width)
//  ADDR_W    2  width of stride (matches PE ADDR_WIDTH_IFMAP)
//  ID_W      4  job identifier width
//  DEPTH     4  job FIFO entries (power of 2, >=2)
//  CNT_W     8  psum write counter width
// PORTS
//  clk              in   1         clock, all logic on rising edge
//  rst              in   1         synchronous, active-high reset
//  job_valid        in   1         job descriptor offered
//  job_ready        out  1         FIFO can accept (= !full)
//  job_id           in   ID_W      job tag
//  job_filter_size  in   FILTER_W  filter size for job
//  job_stride       in   ADDR_W    stride for job
//  pe_start         out  1         one-cycle start pulse to PE
//  pe_filter_size   out  FILTER_W  config held to PE
//  pe_stride        out  ADDR_W    config held to PE
//  pe_ready         out  1         PE data-ready grant
//  pe_done          in   1         PE done_out
//  pe_write_en      in   1         PE write_en_buf (one psum emitted)
//  pe_stall         in   1         PE stall
//  cmpl_valid       out  1         completion record valid
//  cmpl_ready       in   1         completion consumer ready
//  cmpl_id          out  ID_W      id of completed job
//  cmpl_psum_count  out  CNT_W     psums written by that job
//  busy             out  1         state != IDLE or FIFO non-empty
//  stall_cycles     out  CNT_W     only with PE_STALL_COUNT_EN
// BEHAVIOUR
//  Reset: FIFO empty, state IDLE; all outputs 0 except job_ready=1.
//  The config regs and counters are also cleared. Reset mid-job drops the queue and the
//  in-flight job with no completion record.
//  Push on job_valid&&job_ready. Pop happens only in IDLE. Simultaneous push+pop is legal:
//  occupancy is unchanged. Pointers wrap modulo DEPTH. Push while full is ignored.
//  FSM (registered state; outputs decoded from state):
//   IDLE:  FIFO non-empty -> pop head into cfg regs, clear psum cnt -> LOAD
//   LOAD:  cfg stable on pe_* for one cycle (PE setup) -> START
//   START: pe_start=1 for exactly this cycle -> RUN
//   RUN:   pe_ready=1. Each cycle with pe_write_en, psum cnt +1.
//          The counter saturates at 2^CNT_W-1.
//          pe_done=1 -> CMPL (a pe_write_en in the same cycle is counted)
//   CMPL:  cmpl_valid=1 and cmpl_* stable until cmpl_ready.
//          On cmpl_valid&&cmpl_ready -> IDLE.
//  Latency: a push into an empty FIFO in cycle t gives LOAD at t+2 and pe_start at t+3.
//  Completion: cmpl_valid rises the cycle after pe_done.
//  Back-to-back: at cmpl accept, the next IDLE pops next cycle. Min gap done->next
//  pe_start = 4 cycles if cmpl_ready is already high.
//  pe_filter_size/pe_stride change only on IDLE->LOAD. They are held through CMPL.
//  pe_done/pe_write_en outside RUN are ignored (no count, no transition).
//  pe_ready is low outside RUN. pe_stall does not change the FSM.
// CONFIGURATION
//  PE_STALL_COUNT_EN defined: stall_cycles counts RUN cycles with pe_stall=1.
//   It saturates, is cleared on IDLE->LOAD, and is held through CMPL.
//   It is valid alongside cmpl_valid.
//  Undefined: stall_cycles is driven constant 0 and no counter is built.
// TESTING
//  1 Reset: after rst, job_ready=1, busy=0, pe_start=0, cmpl_valid=0, stall_cycles=0.
//  2 Single job: push id=3 fs=2 st=1 at t0 -> pe_start at t0+3.
//    pe_filter_size=2 and pe_stride=1 from t0+2. 5 pe_write_en then pe_done ->
//    cmpl_valid next cycle, id=3, count=5.
//  3 Full queue: push 5 jobs with no pops (hold the PE in RUN) -> job_ready=0 after 4.
//    The 5th push is dropped. Completions come back in order, ids 0,1,2,3.
//  4 Back-pressure: cmpl_ready=0 for 10 cycles -> cmpl_* stable, no new pe_start.
//    Raise cmpl_ready -> next pe_start 3 cycles after the accept.
//  5 Edge events: pe_write_en with pe_done in the same cycle is counted (3+1=4).
//    Spurious pe_done in IDLE is ignored. 300 writes with CNT_W=8 -> count=255.
//  6 Mid-job reset during RUN -> all outputs return to reset values next cycle.
//    No cmpl_valid. With PE_STALL_COUNT_EN, 7 stall cycles in RUN -> stall_cycles=7.

Source files
------------

// File: rtl/pe_job_scheduler.sv
// Job scheduler for one Eyeriss PE: queues {id, filter_size, stride} descriptors and runs them in order.
// Latency: a push into an empty queue reaches LOAD 2 cycles later and pulses pe_start 3 cycles later.
// Backpressure: job_ready = !full (pushes while full are dropped); a completion is held until cmpl_ready.
// Optional macro PE_STALL_COUNT_EN: counts RUN cycles with pe_stall=1 onto stall_cycles.
module pe_job_scheduler #(
  parameter int FILTER_W = 2,
  parameter int ADDR_W   = 2,
  parameter int ID_W     = 4,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                job_valid,
  output logic                job_ready,
  input  logic [ID_W-1:0]     job_id,
  input  logic [FILTER_W-1:0] job_filter_size,
  input  logic [ADDR_W-1:0]   job_stride,
  output logic                pe_start,
  output logic [FILTER_W-1:0] pe_filter_size,
  output logic [ADDR_W-1:0]   pe_stride,
  output logic                pe_ready,
  input  logic                pe_done,
  input  logic                pe_write_en,
  input  logic                pe_stall,
  output logic                cmpl_valid,
  input  logic                cmpl_ready,
  output logic [ID_W-1:0]     cmpl_id,
  output logic [CNT_W-1:0]    cmpl_psum_count,
  output logic                busy,
  output logic [CNT_W-1:0]    stall_cycles
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int ENT_W = ID_W + FILTER_W + ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_RUN, S_CMPL} state_t;

  logic [ENT_W-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]      cnt_q, cnt_d;
  logic                full_w, empty_w, push_w, pop_w;

  state_t              state_q;
  logic [ID_W-1:0]     id_q;
  logic [FILTER_W-1:0] fs_q;
  logic [ADDR_W-1:0]   st_q;
  logic [CNT_W-1:0]    psum_q;
  logic                pe_start_q, pe_ready_q, cmpl_valid_q;

  assign full_w  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_w = (cnt_q == '0);
  assign push_w  = job_valid && !full_w;
  // Pops are only taken from IDLE, so the head is consumed exactly once per job.
  assign pop_w   = (state_q == S_IDLE) && !empty_w;

  // Queue pointer/occupancy next-state; push and pop together leave occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push_w) wr_ptr_d = wr_ptr_q + (PTR_W)'(1);
    if (pop_w)  rd_ptr_d = rd_ptr_q + (PTR_W)'(1);
    if (push_w && !pop_w)      cnt_d = cnt_q + (PTR_W+1)'(1);
    else if (pop_w && !push_w) cnt_d = cnt_q - (PTR_W+1)'(1);
  end

  // Queue pointer/occupancy registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Descriptor storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_w) mem_q[wr_ptr_q] <= {job_id, job_filter_size, job_stride};
  end

  // Job sequencing FSM with registered strobes; config regs only change on IDLE->LOAD.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      id_q         <= '0;
      fs_q         <= '0;
      st_q         <= '0;
      psum_q       <= '0;
      pe_start_q   <= 1'b0;
      pe_ready_q   <= 1'b0;
      cmpl_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty_w) begin
            {id_q, fs_q, st_q} <= mem_q[rd_ptr_q];
            psum_q             <= '0;
            state_q            <= S_LOAD;
          end
        end
        S_LOAD: begin
          pe_start_q <= 1'b1;
          state_q    <= S_START;
        end
        S_START: begin
          pe_start_q <= 1'b0;
          pe_ready_q <= 1'b1;
          state_q    <= S_RUN;
        end
        S_RUN: begin
          // A write coinciding with done still belongs to this job.
          if (pe_write_en && (psum_q != '1)) psum_q <= psum_q + (CNT_W)'(1);
          if (pe_done) begin
            pe_ready_q   <= 1'b0;
            cmpl_valid_q <= 1'b1;
            state_q      <= S_CMPL;
          end
        end
        S_CMPL: begin
          if (cmpl_ready) begin
            cmpl_valid_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          pe_start_q   <= 1'b0;
          pe_ready_q   <= 1'b0;
          cmpl_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign job_ready       = !full_w;
  assign pe_start        = pe_start_q;
  assign pe_ready        = pe_ready_q;
  assign pe_filter_size  = fs_q;
  assign pe_stride       = st_q;
  assign cmpl_valid      = cmpl_valid_q;
  assign cmpl_id         = id_q;
  assign cmpl_psum_count = psum_q;
  assign busy            = (state_q != S_IDLE) || !empty_w;

`ifdef PE_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_q;

  // Saturating count of stalled RUN cycles, restarted when a new job is popped.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if (pop_w) begin
      stall_q <= '0;
    end else if ((state_q == S_RUN) && pe_stall && (stall_q != '1)) begin
      stall_q <= stall_q + (CNT_W)'(1);
    end
  end

  assign stall_cycles = stall_q;
`else
  // The stall input only feeds the optional counter.
  logic unused_pe_stall;
  assign unused_pe_stall = pe_stall;
  assign stall_cycles    = '0;
`endif

endmodule

// File: tb/tb_pe_job_scheduler.sv
// Directed bench for pe_job_scheduler: reset, single job, full queue, back-pressure, edge events, mid-job reset.
// Inputs are driven 1 time unit after each rising edge; outputs are sampled at that same point.
// Each check is an immediate assertion that counts failures and reports tag/observed/expected.
module tb_pe_job_scheduler;
  localparam int FILTER_W = 2;
  localparam int ADDR_W   = 2;
  localparam int ID_W     = 4;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 8;
`ifdef PE_STALL_COUNT_EN
  localparam int STALL_EXP = 7;
`else
  localparam int STALL_EXP = 0;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                job_valid;
  logic                job_ready;
  logic [ID_W-1:0]     job_id;
  logic [FILTER_W-1:0] job_filter_size;
  logic [ADDR_W-1:0]   job_stride;
  logic                pe_start;
  logic [FILTER_W-1:0] pe_filter_size;
  logic [ADDR_W-1:0]   pe_stride;
  logic                pe_ready;
  logic                pe_done;
  logic                pe_write_en;
  logic                pe_stall;
  logic                cmpl_valid;
  logic                cmpl_ready;
  logic [ID_W-1:0]     cmpl_id;
  logic [CNT_W-1:0]    cmpl_psum_count;
  logic                busy;
  logic [CNT_W-1:0]    stall_cycles;

  int tests = 0;
  int fails = 0;

  pe_job_scheduler #(
    .FILTER_W(FILTER_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .job_valid(job_valid), .job_ready(job_ready), .job_id(job_id),
    .job_filter_size(job_filter_size), .job_stride(job_stride),
    .pe_start(pe_start), .pe_filter_size(pe_filter_size), .pe_stride(pe_stride),
    .pe_ready(pe_ready), .pe_done(pe_done), .pe_write_en(pe_write_en), .pe_stall(pe_stall),
    .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready), .cmpl_id(cmpl_id),
    .cmpl_psum_count(cmpl_psum_count), .busy(busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input int fs, input int st);
    job_valid       = 1'b1;
    job_id          = ID_W'(id);
    job_filter_size = FILTER_W'(fs);
    job_stride      = ADDR_W'(st);
    tick();
    job_valid       = 1'b0;
  endtask

  // Advance until pe_start is seen (bounded); returns in the START cycle.
  task automatic wait_start(input string tag);
    int n = 0;
    while (pe_start !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) check({tag, " start_timeout"}, 0, 1);
  endtask

  // From the START cycle: run nwr write cycles, then done (optionally with a write), accept completion.
  task automatic finish_job(input int nwr, input logic wr_on_done, input int exp_id,
                            input int exp_cnt, input string tag);
    tick();
    check({tag, " pe_ready"}, pe_ready, 1);
    pe_write_en = 1'b1;
    repeat (nwr) tick();
    pe_write_en = wr_on_done;
    pe_done     = 1'b1;
    tick();
    pe_done     = 1'b0;
    pe_write_en = 1'b0;
    check({tag, " cmpl_valid"}, cmpl_valid, 1);
    check({tag, " cmpl_id"}, cmpl_id, exp_id);
    check({tag, " cmpl_count"}, cmpl_psum_count, exp_cnt);
    cmpl_ready = 1'b1;
    tick();
    cmpl_ready = 1'b0;
    check({tag, " cmpl_drop"}, cmpl_valid, 0);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; job_id = '0; job_filter_size = '0; job_stride = '0;
    pe_done = 1'b0; pe_write_en = 1'b0; pe_stall = 1'b0; cmpl_ready = 1'b0;

    // 1: reset values
    repeat (3) tick();
    check("rst job_ready", job_ready, 1);
    check("rst busy", busy, 0);
    check("rst pe_start", pe_start, 0);
    check("rst cmpl_valid", cmpl_valid, 0);
    check("rst stall_cycles", stall_cycles, 0);
    check("rst pe_ready", pe_ready, 0);
    check("rst pe_filter_size", pe_filter_size, 0);
    rst = 1'b0;
    tick();

    // 2: single job, exact latency (push cycle t0)
    check("single job_ready", job_ready, 1);
    push(3, 2, 1);                                   // now at t0+1
    check("single busy t1", busy, 1);
    check("single pe_start t1", pe_start, 0);
    tick();                                          // t0+2: LOAD
    check("single pe_filter_size t2", pe_filter_size, 2);
    check("single pe_stride t2", pe_stride, 1);
    check("single pe_start t2", pe_start, 0);
    tick();                                          // t0+3: START
    check("single pe_start t3", pe_start, 1);
    check("single pe_ready t3", pe_ready, 0);
    finish_job(5, 1'b0, 3, 5, "single");
    check("single busy end", busy, 0);
    check("single cfg held", pe_filter_size, 2);

    // 3: full queue while the PE is held in RUN by job 7
    push(7, 1, 1);
    wait_start("hold");
    tick();
    check("hold pe_ready", pe_ready, 1);
    for (int i = 0; i < 5; i++) begin
      job_valid       = 1'b1;
      job_id          = ID_W'(i);
      job_filter_size = FILTER_W'(i);
      job_stride      = ADDR_W'(3 - i);
      check($sformatf("full job_ready before push %0d", i), job_ready, (i < 4) ? 1 : 0);
      tick();
    end
    job_valid = 1'b0;
    check("full job_ready after", job_ready, 0);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    check("hold cmpl_id", cmpl_id, 7);
    cmpl_ready = 1'b1;
    tick();
    cmpl_ready = 1'b0;

    // job 0, then 10 cycles of completion back-pressure
    wait_start("q0");
    check("q0 pe_filter_size", pe_filter_size, 0);
    check("q0 pe_stride", pe_stride, 3);
    tick();
    pe_write_en = 1'b1;
    repeat (2) tick();
    pe_write_en = 1'b0;
    pe_done     = 1'b1;
    tick();
    pe_done     = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp cmpl_valid %0d", i), cmpl_valid, 1);
      check($sformatf("bp cmpl_id %0d", i), cmpl_id, 0);
      check($sformatf("bp cmpl_count %0d", i), cmpl_psum_count, 2);
      check($sformatf("bp pe_start %0d", i), pe_start, 0);
      tick();
    end
    cmpl_ready = 1'b1;                               // accept cycle A
    tick();
    cmpl_ready = 1'b0;
    check("bp pe_start A+1", pe_start, 0);
    tick();
    check("bp pe_start A+2", pe_start, 0);
    check("bp q1 filter", pe_filter_size, 1);
    tick();
    check("bp pe_start A+3", pe_start, 1);
    finish_job(0, 1'b0, 1, 0, "q1");

    // job 2: minimum done -> next pe_start gap with cmpl_ready already high
    wait_start("q2");
    tick();
    cmpl_ready = 1'b1;
    pe_done    = 1'b1;
    tick();                                          // d+1
    pe_done    = 1'b0;
    check("gap cmpl_valid", cmpl_valid, 1);
    check("gap cmpl_id", cmpl_id, 2);
    tick();                                          // d+2
    cmpl_ready = 1'b0;
    check("gap pe_start d+2", pe_start, 0);
    tick();                                          // d+3
    check("gap pe_start d+3", pe_start, 0);
    tick();                                          // d+4
    check("gap pe_start d+4", pe_start, 1);
    check("q3 filter", pe_filter_size, 3);
    finish_job(1, 1'b0, 3, 1, "q3");
    repeat (5) tick();
    check("dropped 5th busy", busy, 0);
    check("dropped 5th pe_start", pe_start, 0);

    // 5: edge events
    pe_done = 1'b1; pe_write_en = 1'b1;
    repeat (3) tick();
    pe_done = 1'b0; pe_write_en = 1'b0;
    check("spurious busy", busy, 0);
    check("spurious cmpl_valid", cmpl_valid, 0);
    check("spurious pe_ready", pe_ready, 0);
    push(5, 2, 2);
    wait_start("edge");
    finish_job(3, 1'b1, 5, 4, "edge");
    push(6, 3, 0);
    wait_start("sat");
    finish_job(300, 1'b0, 6, 255, "sat");

    // 6a: stall counting, held through completion
    push(8, 1, 2);
    wait_start("stall");
    tick();
    pe_stall = 1'b1;
    repeat (7) tick();
    pe_stall = 1'b0;
    check("stall run count", stall_cycles, STALL_EXP);
    pe_done = 1'b1;
    tick();
    pe_done = 1'b0;
    check("stall cmpl_id", cmpl_id, 8);
    check("stall cmpl count", stall_cycles, STALL_EXP);
    cmpl_ready = 1'b1;
    tick();
    cmpl_ready = 1'b0;

    // 6b: reset in RUN with another job queued
    push(9, 3, 2);
    wait_start("mid");
    tick();
    pe_stall = 1'b1;
    push(10, 1, 1);
    pe_stall = 1'b0;
    check("mid pe_ready", pe_ready, 1);
    rst = 1'b1;
    tick();
    check("mid rst job_ready", job_ready, 1);
    check("mid rst busy", busy, 0);
    check("mid rst pe_ready", pe_ready, 0);
    check("mid rst pe_filter_size", pe_filter_size, 0);
    check("mid rst pe_stride", pe_stride, 0);
    check("mid rst cmpl_valid", cmpl_valid, 0);
    check("mid rst stall_cycles", stall_cycles, 0);
    check("mid rst cmpl_count", cmpl_psum_count, 0);
    rst = 1'b0;
    repeat (6) tick();
    check("mid after busy", busy, 0);
    check("mid after cmpl_valid", cmpl_valid, 0);
    check("mid after pe_start", pe_start, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
